// File: rtl/store_merge_rmw.sv
// Store path to the 64-bit data memory: doublewords write directly, byte/half/word run read-merge-write.
// Latency from accept: dword write in cycle 1; partial read in cycle 1, write in cycle 3.
// Backpressure: st_ready only in IDLE; misaligned requests are rejected with a one-cycle pulse.
module store_merge_rmw #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [63:0]       st_data,
    input  logic              byteword,
    input  logic              halfword,
    input  logic              word,
    output logic [ADDR_W-4:0] mem_addr,
    output logic              mem_re,
    input  logic [63:0]       mem_rdata,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    output logic              done,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-4:0] mem_addr_q, mem_addr_d;
    logic [63:0]       wbuf_q, wbuf_d;
    logic [7:0]        mask_q, mask_d;
    logic              misaligned_q, misaligned_d;

    logic [2:0]        req_off;
    logic [7:0]        req_mask;
    logic              req_dword;
    logic              req_aligned;
    logic              accept;
    logic [63:0]       lane_bits;

    assign req_off = st_addr[2:0];
    assign accept  = st_valid & st_ready;

    // Size decode with word > half > byte > dword priority; mask is the byte lanes the store touches.
    always_comb begin
        req_mask    = 8'hFF;
        req_dword   = 1'b0;
        req_aligned = 1'b0;
        if (word) begin
            req_mask    = 8'h0F << req_off;
            req_aligned = (req_off[1:0] == 2'b00);
        end else if (halfword) begin
            req_mask    = 8'h03 << req_off;
            req_aligned = ~req_off[0];
        end else if (byteword) begin
            req_mask    = 8'h01 << req_off;
            req_aligned = 1'b1;
        end else begin
            req_mask    = 8'hFF;
            req_dword   = 1'b1;
            req_aligned = (req_off == 3'b000);
        end
    end

    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < 8; i++) begin
            lane_bits[8*i +: 8] = {8{mask_q[i]}};
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        wbuf_d       = wbuf_q;
        mask_d       = mask_q;
        misaligned_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!req_aligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        mem_addr_d = st_addr[ADDR_W-1:3];
                        mask_d     = req_mask;
                        if (req_dword) begin
                            wbuf_d  = st_data;
                            state_d = S_WRITE;
                        end else begin
                            // Pre-shift into lane position; bytes outside the mask are discarded at merge.
                            wbuf_d  = st_data << {req_off, 3'b000};
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wbuf_d  = (mem_rdata & ~lane_bits) | (wbuf_q & lane_bits);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            wbuf_q       <= '0;
            mask_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            wbuf_q       <= wbuf_d;
            mask_q       <= mask_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign st_ready   = (state_q == S_IDLE);
    assign mem_re     = (state_q == S_READ);
    assign mem_we     = (state_q == S_WRITE);
    assign done       = (state_q == S_WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = wbuf_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: small word memory, write scoreboard, per-scenario timing checks.
module tb_store_merge_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [9:0]  st_addr;
    logic [63:0] st_data;
    logic        byteword, halfword, word;
    logic [6:0]  mem_addr;
    logic        mem_re;
    logic [63:0] mem_rdata;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic        done;
    logic        misaligned;

    typedef struct packed {
        logic [6:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mem [128];
    int          n_cmp = 0;
    int          n_err = 0;
    int          re_cnt = 0;
    int          we_cnt = 0;

    store_merge_rmw #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .byteword(byteword), .halfword(halfword),
        .word(word), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_re) re_cnt++;
        if (mem_we) begin
            we_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr=%0d data=%h, none expected", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata, done} !== {e.addr, e.data, 1'b1}) begin
                    n_err++;
                    $display("FAIL write_data: got addr=%0d data=%h done=%b, want addr=%0d data=%h done=1",
                             mem_addr, mem_wdata, done, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [63:0] merge_ref(input logic [63:0] old, input logic [63:0] d,
                                              input int off, input int n);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < n; b++) r[8*(off+b) +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic exp_t mk(input logic [6:0] a, input logic [63:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic send(input logic [9:0] a, input logic [63:0] d, input logic b, input logic h,
                        input logic w);
        st_valid = 1'b1; st_addr = a; st_data = d; byteword = b; halfword = h; word = w;
        @(posedge clk);
        #1;
        st_valid = 1'b0; byteword = 1'b0; halfword = 1'b0; word = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        byteword = 1'b0; halfword = 1'b0; word = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        @(negedge clk);
        n_cmp++;
        if ({st_ready, mem_re, mem_we, done, misaligned} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy/re/we/done/mis=%b want 10000",
                     {st_ready, mem_re, mem_we, done, misaligned});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 71'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%0d wdata=%h want 0/0", mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dword();
        int re0;
        re0 = re_cnt;
        exp_q.push_back(mk(7'd2, 64'h1122334455667788));
        send(10'h10, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({mem_we, done, mem_addr} !== {1'b1, 1'b1, 7'd2}) begin
            n_err++;
            $display("FAIL dword_cycle1: got we=%b done=%b addr=%0d want 1 1 2", mem_we, done, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (re_cnt !== re0 || st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL dword_no_read: got reads=%0d ready=%b want 0 1", re_cnt - re0, st_ready);
        end
    endtask

    task automatic test_byte();
        mem[2] = 64'hFFEEDDCCBBAA9988;
        exp_q.push_back(mk(7'd2, 64'hFFEEDDCCABAA9988));
        send(10'h13, 64'hFFFF_FFFF_FFFF_FFAB, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({mem_re, mem_we, st_ready, mem_addr} !== {3'b100, 7'd2}) begin
            n_err++;
            $display("FAIL byte_cycle1: got re=%b we=%b rdy=%b addr=%0d want 1 0 0 2",
                     mem_re, mem_we, st_ready, mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_re, mem_we} !== 2'b00) begin
            n_err++;
            $display("FAIL byte_cycle2: got re=%b we=%b want 0 0", mem_re, mem_we);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_we, done} !== 2'b11) begin
            n_err++;
            $display("FAIL byte_cycle3: got we=%b done=%b want 1 1", mem_we, done);
        end
        @(negedge clk);
    endtask

    task automatic test_half_word();
        mem[2] = 64'h0;
        exp_q.push_back(mk(7'd2, 64'h1234000000000000));
        send(10'h16, 64'h0000_0000_0000_1234, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        mem[1] = 64'h1111111122222222;
        exp_q.push_back(mk(7'd1, 64'hDEADBEEF22222222));
        // Byte flag also set: word must win.
        send(10'h0C, 64'h5555_5555_DEAD_BEEF, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL word_cycle2: got we=%b want 0", mem_we);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_partials();
        for (int k = 0; k < 6; k++) begin
            int          n, off;
            logic [6:0]  idx;
            logic [63:0] d, old;
            n   = 1 << $urandom_range(0, 2);
            off = ($urandom_range(0, 7) / n) * n;
            idx = 7'($urandom_range(0, 127));
            old = {$urandom, $urandom};
            d   = {$urandom, $urandom};
            mem[idx] = old;
            exp_q.push_back(mk(idx, merge_ref(old, d, off, n)));
            send({idx, 3'(off)}, d, n == 1, n == 2, n == 4);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_misaligned();
        logic [9:0] addrs [4] = '{10'h0A, 10'h05, 10'h14, 10'h21};
        logic [2:0] flags [4] = '{3'b101, 3'b010, 3'b000, 3'b011};
        int re0, we0;
        re0 = re_cnt; we0 = we_cnt;
        for (int k = 0; k < 4; k++) begin
            send(addrs[k], 64'hA5A5_A5A5_A5A5_A5A5, flags[k][0], flags[k][1], flags[k][2]);
            @(negedge clk);
            n_cmp++;
            if ({misaligned, st_ready} !== 2'b11) begin
                n_err++;
                $display("FAIL misaligned_%0d: got mis=%b rdy=%b want 1 1", k, misaligned, st_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (misaligned !== 1'b0) begin
                n_err++;
                $display("FAIL misaligned_pulse_%0d: got mis=%b want 0", k, misaligned);
            end
        end
        n_cmp++;
        if (re_cnt !== re0 || we_cnt !== we0) begin
            n_err++;
            $display("FAIL misaligned_no_access: got reads=%0d writes=%0d want 0 0",
                     re_cnt - re0, we_cnt - we0);
        end
    endtask

    task automatic test_reset_mid();
        int we0;
        we0 = we_cnt;
        mem[5] = 64'h0123456789ABCDEF;
        send(10'h29, 64'h77, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we, done, st_ready, mem_wdata, mem_addr} !== {3'b001, 64'h0, 7'd0}) begin
            n_err++;
            $display("FAIL reset_mid_now: got we=%b done=%b rdy=%b wdata=%h addr=%0d want 0 0 1 0 0",
                     mem_we, done, st_ready, mem_wdata, mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (we_cnt !== we0 || st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_after: got writes=%0d rdy=%b want 0 1", we_cnt - we0, st_ready);
        end
        exp_q.push_back(mk(7'd2, 64'hFEDCBA9876543210));
        send(10'h10, 64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({mem_we, done, mem_addr} !== {1'b1, 1'b1, 7'd2}) begin
            n_err++;
            $display("FAIL reset_mid_dword: got we=%b done=%b addr=%0d want 1 1 2", mem_we, done, mem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        mem[3] = 64'h0706050403020100;
        exp_q.push_back(mk(7'd3, 64'h070605040302015A));
        exp_q.push_back(mk(7'd4, 64'hCAFEF00D12345678));
        st_valid = 1'b1; st_addr = 10'h18; st_data = 64'h5A; byteword = 1'b1;
        @(posedge clk); #1;
        st_addr = 10'h20; st_data = 64'hCAFEF00D12345678; byteword = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (st_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready_cycle%0d: got %b want 0", c, st_ready);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_cycle4: got %b want 1", st_ready);
        end
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b1, 7'd4}) begin
            n_err++;
            $display("FAIL b2b_second_write: got we=%b addr=%0d want 1 4", mem_we, mem_addr);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dword();
        test_byte();
        test_half_word();
        test_random_partials();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL pending_writes: got %0d outstanding want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
